muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer that performs unsigned 32x32 multiply (64-bit product) and unsigned 32/32 divide (quotient and remainder).
- It has no adder of its own. It drives one shared ALU instance through an operand/op port and reads back the ALU result.
- The ALU is used for ADD (op 010) on multiply steps and SUB (op 110) on divide steps.
- Sits beside the ALU in the execute stage. The pipeline talks to it through a valid/ready request channel and a valid/ready response channel.

Parameters:
WIDTH, 32, operand width; must equal the ALU width.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  1  0 = multiply, 1 = divide
req_a  in  WIDTH  multiplicand / dividend
req_b  in  WIDTH  multiplier / divisor
rsp_valid  out  1  result present
rsp_ready  in  1  consumer takes result
rsp_hi  out  WIDTH  product high word / remainder
rsp_lo  out  WIDTH  product low word / quotient
rsp_dbz  out  1  divide-by-zero flag
alu_a  out  WIDTH  ALU operand A
alu_b  out  WIDTH  ALU operand B
alu_op  out  3  ALU op (010 add, 110 sub)
alu_z  in  WIDTH  ALU result (combinational)
busy  out  1  high in RUN or DONE

Behaviour:
- Interface: single clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, all data registers 0, rsp_valid=0, rsp_dbz=0, busy=0. req_ready=1 from IDLE.
- Reset mid-operation: the in-flight operation is discarded; no response is produced.

States and transitions:
- IDLE: req_ready=1.
  - On req_valid&req_ready, latch op/a/b and set cnt=0.
  - Divide with req_b==0 goes to DONE with hi=a, lo=all-ones, dbz=1.
  - Otherwise go to RUN.
- RUN: one iteration per cycle. After the iteration with cnt==WIDTH-1, go to DONE; otherwise cnt+1.
- DONE: rsp_valid=1, outputs stable. On rsp_ready, go to IDLE. rsp_ready is ignored outside DONE.
- No request is accepted in RUN or DONE (req_ready=0).

Multiply step (registers P=hi, L=lo, M=multiplicand; P=0, L=b at accept):
- alu_a=P, alu_b=(L[0] ? M : 0), alu_op=010.
- Carry out: c = (a31&b31) | ((a31|b31) & ~z31).
- Next state: {P,L} <= {c, alu_z, L} >> 1, keeping the low 2*WIDTH bits.

Divide step (R=hi=0, Q=lo=dividend, D=divisor at accept):
- s = R[WIDTH-1]; Rs = {R[WIDTH-2:0], Q[WIDTH-1]}.
- alu_a=Rs, alu_b=D, alu_op=110.
- Borrow: bw = (~a31&b31) | (~(a31^b31) & z31).
- If s | ~bw: R<=alu_z, Q<={Q[WIDTH-2:0],1}. Else: R<=Rs, Q<={Q[WIDTH-2:0],0}.

ALU port outside RUN: alu_a=0, alu_b=0, alu_op=010. All ALU outputs are combinational from registers only, with no path from req_* or alu_z.

Latency:
- Normal: handshake at edge E, rsp_valid high in cycle E+33 (32 RUN cycles).
- Divide by zero: rsp_valid high in cycle E+1.
- Back-to-back: next request accepted one cycle after the response handshake.

Optional Feature:
MULDIV_SIGNED_EN:
- Defined:
  - Adds input req_signed (1 bit), latched at accept.
  - When set, operands are replaced by their magnitudes at accept.
  - After RUN, an extra FIX state (1 cycle) negates results: product if signs differ; quotient if signs differ; remainder takes the dividend sign.
  - Latency becomes E+34 for signed requests.
  - Divide by zero: hi=original a, lo=all-ones.
  - Negation is internal and does not use the ALU.
- Undefined: no port, no FIX state, unsigned only.

Test Plan:
- Multiply a=7, b=6 -> rsp_hi=0x00000000, rsp_lo=0x0000002A, dbz=0; rsp_valid exactly 33 cycles after accept; req_ready=0 throughout.
- Multiply a=0xFFFFFFFF, b=0xFFFFFFFF -> rsp_hi=0xFFFFFFFE, rsp_lo=0x00000001 (exercises derived carry every step).
- Divide a=100, b=7 -> rsp_lo=14, rsp_hi=2. Divide a=0x80000000, b=0x80000001 -> lo=0, hi=0x80000000. Divide a=0xFFFFFFFF, b=1 -> lo=0xFFFFFFFF, hi=0.
- Divide a=5, b=0 -> rsp_valid next cycle, rsp_hi=5, rsp_lo=0xFFFFFFFF, rsp_dbz=1.
- Hold rsp_ready=0 for 5 cycles in DONE with req_valid=1 -> outputs stable, req_ready=0. Then rsp_ready=1 -> IDLE next cycle, new request accepted.
- Assert rst at RUN cycle 10 -> state IDLE immediately, rsp_valid=0, no response. New multiply 3x3 after release -> lo=9.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned 32x32 multiply / 32/32 divide sequencer that drives an external shared ALU.
// Optional signed support: define MULDIV_SIGNED_EN (adds req_signed and a one-cycle FIX state).
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
`ifdef MULDIV_SIGNED_EN
  input  logic             req_signed,
`endif
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_dbz,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
`ifdef MULDIV_SIGNED_EN
    , S_FIX = 2'd3
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   rs;
  logic               s, carry, borrow;
`ifdef MULDIV_SIGNED_EN
  logic               sgn_q, sgn_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [2*WIDTH-1:0] prod_neg;
`endif

  assign s  = hi_q[WIDTH-1];
  assign rs = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

  // Carry/borrow recovered from operand and result sign bits, since the ALU exports neither.
  assign carry  = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                  ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_z[WIDTH-1]);
  assign borrow = (~alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                  (~(alu_a[WIDTH-1] ^ alu_b[WIDTH-1]) & alu_z[WIDTH-1]);

`ifdef MULDIV_SIGNED_EN
  assign a_mag    = (req_signed & req_a[WIDTH-1]) ? (~req_a + 1'b1) : req_a;
  assign b_mag    = (req_signed & req_b[WIDTH-1]) ? (~req_b + 1'b1) : req_b;
  assign prod_neg = ~{hi_q, lo_q} + 1'b1;
`else
  assign a_mag = req_a;
  assign b_mag = req_b;
`endif

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 3'b010;
    if (state_q == S_RUN) begin
      if (op_q) begin
        alu_a  = rs;
        alu_b  = m_q;
        alu_op = 3'b110;
      end else begin
        alu_a = hi_q;
        alu_b = lo_q[0] ? m_q : '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    dbz_d     = dbz_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn_d     = sgn_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d  = req_op;
          cnt_d = '0;
          dbz_d = 1'b0;
          hi_d  = '0;
`ifdef MULDIV_SIGNED_EN
          sgn_d    = req_signed;
          neg_lo_d = req_signed & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
          neg_hi_d = req_op ? (req_signed & req_a[WIDTH-1]) : neg_lo_d;
`endif
          if (req_op && (req_b == '0)) begin
            hi_d    = req_a;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            lo_d    = req_op ? a_mag : b_mag;
            m_d     = req_op ? b_mag : a_mag;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (op_q) begin
          if (s | ~borrow) begin
            hi_d = alu_z;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = rs;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_d = {carry, alu_z[WIDTH-1:1]};
          lo_d = {alu_z[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH-1)) begin
`ifdef MULDIV_SIGNED_EN
          state_d = sgn_q ? S_FIX : S_DONE;
`else
          state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_FIX: begin
        if (op_q) begin
          if (neg_lo_q) lo_d = ~lo_q + 1'b1;
          if (neg_hi_q) hi_d = ~hi_q + 1'b1;
        end else if (neg_lo_q) begin
          {hi_d, lo_d} = prod_neg;
        end
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      dbz_q    <= dbz_d;
`ifdef MULDIV_SIGNED_EN
      sgn_q    <= sgn_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  assign rsp_hi  = hi_q;
  assign rsp_lo  = lo_q;
  assign rsp_dbz = dbz_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed and random multiply/divide against arithmetic reference.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_dbz;
  logic [31:0] rsp_hi, rsp_lo;
  logic [31:0] alu_a, alu_b, alu_z;
  logic [2:0]  alu_op;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Shared ALU stand-in: add for 010, subtract for 110.
  assign alu_z = (alu_op == 3'b110) ? (alu_a - alu_b) : (alu_a + alu_b);

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_dbz(rsp_dbz),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: plain 64-bit arithmetic.
  task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic dbz, output int lat);
    logic [63:0] p;
    if (!op) begin
      p = 64'(a) * 64'(b);
      hi = p[63:32]; lo = p[31:0]; dbz = 1'b0; lat = 32;
    end else if (b == 0) begin
      hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1; lat = 0;
    end else begin
      hi = a % b; lo = a / b; dbz = 1'b0; lat = 32;
    end
  endtask

  task automatic do_op(input string tag, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    logic [31:0] ehi, elo, shi, slo;
    logic        edbz, bad_ready;
    int          elat, lat;
    model(op, a, b, ehi, elo, edbz, elat);
    @(negedge clk);
    check({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; bad_ready = 1'b0;
    while (!rsp_valid && lat < 100) begin
      if (req_ready) bad_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_ready_busy"}, 64'(bad_ready | req_ready), 64'd0);
    check({tag, "_hi"}, 64'(rsp_hi), 64'(ehi));
    check({tag, "_lo"}, 64'(rsp_lo), 64'(elo));
    check({tag, "_dbz"}, 64'(rsp_dbz), 64'(edbz));
    shi = rsp_hi; slo = rsp_lo;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = 1'b0; req_a = $urandom; req_b = $urandom;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
      check({tag, "_hold_data"}, {rsp_hi, rsp_lo}, {shi, slo});
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_after_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_after_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic       rop;
    logic [31:0] ra, rb;
    int         seen;
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_dbz", 64'(rsp_dbz), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_data", {rsp_hi, rsp_lo}, 64'd0);
    check("rst_alu", {29'd0, alu_op, alu_a}, {29'd0, 3'b010, 32'd0});
    @(negedge clk); rst = 1'b0;

    do_op("mul7x6", 1'b0, 32'd7, 32'd6, 0);
    do_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("div100_7", 1'b1, 32'd100, 32'd7, 0);
    do_op("div_big", 1'b1, 32'h8000_0000, 32'h8000_0001, 0);
    do_op("div_by1", 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("div_dbz", 1'b1, 32'd5, 32'd0, 0);
    do_op("hold", 1'b1, 32'd1000, 32'd33, 5);
    do_op("b2b", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd11; req_b = 32'd13;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1; #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("mid_no_rsp", 64'(seen), 64'd0);
    do_op("mul3x3", 1'b0, 32'd3, 32'd3, 0);

    for (int k = 0; k < 24; k++) begin
      rop = 1'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      if (k % 4 == 1) rb = rb >> $urandom_range(31, 16);
      if (k % 8 == 3) rb = 32'd0;
      do_op($sformatf("rnd%0d", k), rop, ra, rb, k % 5 == 0 ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
